// File: rtl/risc32_multicycle_cpu_if.sv
// Shared instruction/data memory bus of the multicycle core.
interface risc32_multicycle_cpu_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_wen;

    modport master (output mem_addr, output mem_wdata, output mem_wen, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_wen, output mem_rdata);
endinterface

// File: rtl/risc32_multicycle_cpu.sv
// MIPS-style multicycle core (FETCH/DECODE/EXEC/MEM/WB) on one word-addressed memory port.
// Optional feature macro: CPU_BRANCH_EN enables BEQ/BNE; without it they decode as NOPs.
module risc32_multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                           clk,
    input  logic                           reset,
    risc32_multicycle_cpu_if.master        mem,
    output logic [7:0]                     pc_debug,
    output logic [2:0]                     state_debug
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

`ifdef CPU_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, ir, a, b, alu_out, mdr;
    logic [XLEN-1:0]   rf [NREG];

    logic              ir_ld, pc_ld, ab_ld, alu_ld, mdr_ld, rf_we;
    logic [XLEN-1:0]   pc_nxt, alu_res, rf_wdata;
    logic [4:0]        rf_waddr;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [XLEN-1:0]   imm_sext;
    logic              is_branch, br_taken, funct_ok, op_known;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    assign is_branch = BRANCH_EN && ((op == OP_BEQ) || (op == OP_BNE));
    assign br_taken  = (op == OP_BEQ) ? (a == b) : (a != b);
    assign funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                       (funct == FN_OR)  || (funct == FN_SLT);
    assign op_known  = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
                       (op == OP_SW) || is_branch;

    // ALU: R-type operation or base+offset for ADDI/LW/SW
    always_comb begin
        alu_res = a + imm_sext;
        if (op == OP_R) begin
            case (funct)
                FN_ADD:  alu_res = a + b;
                FN_SUB:  alu_res = a - b;
                FN_AND:  alu_res = a & b;
                FN_OR:   alu_res = a | b;
                FN_SLT:  alu_res = XLEN'($signed(a) < $signed(b));
                default: alu_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next state and datapath strobes
    always_comb begin
        state_nxt = S_FETCH;
        ir_ld     = 1'b0;
        pc_ld     = 1'b0;
        pc_nxt    = pc;
        ab_ld     = 1'b0;
        alu_ld    = 1'b0;
        mdr_ld    = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out;
        case (state)
            S_FETCH: begin
                ir_ld     = 1'b1;
                pc_ld     = 1'b1;
                pc_nxt    = pc + XLEN'(1);
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ab_ld = 1'b1;
                if (op == OP_J) begin
                    pc_ld  = 1'b1;
                    pc_nxt = {pc[31:26], ir[25:0]};
                end else if (op_known) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_ld  = br_taken;
                    pc_nxt = pc + imm_sext;
                end else begin
                    alu_ld    = 1'b1;
                    state_nxt = ((op == OP_LW) || (op == OP_SW)) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    mdr_ld    = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (op == OP_LW) begin
                    rf_we    = 1'b1;
                    rf_wdata = mdr;
                end else if (op == OP_ADDI) begin
                    rf_we = 1'b1;
                end else if ((op == OP_R) && funct_ok) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if (pc_ld)  pc      <= pc_nxt;
            if (ir_ld)  ir      <= mem.mem_rdata;
            if (ab_ld)  a       <= rf[rs];
            if (ab_ld)  b       <= rf[rt];
            if (alu_ld) alu_out <= alu_res;
            if (mdr_ld) mdr     <= mem.mem_rdata;
        end
    end

    // Register file; R0 is never written so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    assign mem.mem_addr  = (state == S_MEM) ? alu_out : pc;
    assign mem.mem_wdata = b;
    assign mem.mem_wen   = (state == S_MEM) && (op == OP_SW);
    assign pc_debug      = pc[7:0];
    assign state_debug   = state;
endmodule

// File: tb/tb_risc32_multicycle_cpu.sv
// Directed bench for risc32_multicycle_cpu with a RAM model and a store scoreboard.
module tb_risc32_multicycle_cpu;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc_debug;
    logic [2:0] state_debug;

    risc32_multicycle_cpu_if bus ();

    risc32_multicycle_cpu #(.RESET_PC(32'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (bus),
        .pc_debug    (pc_debug),
        .state_debug (state_debug)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:127];
    assign bus.mem_rdata = ram[bus.mem_addr[6:0]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q [$];

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    // Memory commits stores on the falling edge; each store is checked against the queue
    always @(negedge clk) begin
        if (bus.mem_wen === 1'b1) begin
            wr_t e;
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected=none",
                       bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("store_addr", bus.mem_addr, e.addr);
                chk("store_data", bus.mem_wdata, e.data);
            end
            ram[bus.mem_addr[6:0]] = bus.mem_wdata;
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < 128; i++) ram[i] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic next_fetch(input string tag, output int ncyc);
        bit found = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            ncyc++;
            if (state_debug == 3'd0) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_fetch_at(input logic [7:0] pc, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (state_debug == 3'd0 && pc_debug == pc) found = 1'b1;
            else @(negedge clk);
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic load_prog1();
        clear_ram();
        ram[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'd60);
        ram[1]  = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
        ram[2]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd61);
        ram[3]  = enc_j(26'd0);
        ram[60] = 32'h0000_0005;
    endtask

    initial begin
        int exp_st [16] = '{0,1,2,3,4, 0,1,2,4, 0,1,2,3, 0,1, 0};
        int exp_pc [16] = '{0,1,1,1,1, 1,2,2,2, 2,3,3,3, 3,4, 0};
        int wen_cyc;
        int wen_n;
        int ncyc;
        int base;
        bit found;

        reset = 1'b1;
        clear_ram();

        // Load-increment-store loop, with a per-cycle trace of state and PC
        load_prog1();
        exp_q.push_back('{addr: 32'd61, data: 32'd6});
        @(negedge clk);
        chk("reset_state", 32'(state_debug), 32'd0);
        chk("reset_pc", 32'(pc_debug), 32'd0);
        chk("reset_wen", 32'(bus.mem_wen), 32'd0);
        chk("reset_wdata", bus.mem_wdata, 32'd0);
        chk("reset_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        wen_cyc = 0;
        wen_n   = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            chk($sformatf("trace_state_c%0d", cyc), 32'(state_debug), 32'(exp_st[cyc-1]));
            chk($sformatf("trace_pc_c%0d", cyc), 32'(pc_debug), 32'(exp_pc[cyc-1]));
            if (cyc == 4)  chk("lw_mem_addr", bus.mem_addr, 32'd60);
            if (cyc == 13) chk("sw_mem_addr", bus.mem_addr, 32'd61);
            if (bus.mem_wen === 1'b1) begin
                wen_cyc = cyc;
                wen_n++;
            end
            if (cyc < 16) @(negedge clk);
        end
        chk("sw_cycle", 32'(wen_cyc), 32'd13);
        chk("sw_count", 32'(wen_n), 32'd1);
        chk("ram61", ram[61], 32'd6);
        chk("q_empty_prog1", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while in EXEC
        load_prog1();
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (state_debug == 3'd2) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_exec", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_pc", 32'(pc_debug), 32'd0);
        chk("async_rst_state", 32'(state_debug), 32'd0);
        chk("async_rst_wen", 32'(bus.mem_wen), 32'd0);
        chk("async_rst_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type ALU ops, signed SLT, and writes to R0 being ignored
        clear_ram();
        ram[0]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        ram[1]  = enc_i(6'h08, 5'd0, 5'd3, 16'd9);
        ram[2]  = enc_r(5'd2, 5'd3, 5'd4, 6'h22);
        ram[3]  = enc_r(5'd2, 5'd3, 5'd5, 6'h2A);
        ram[4]  = enc_r(5'd2, 5'd3, 5'd6, 6'h24);
        ram[5]  = enc_r(5'd2, 5'd3, 5'd7, 6'h25);
        ram[6]  = enc_r(5'd2, 5'd3, 5'd8, 6'h20);
        ram[7]  = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
        ram[8]  = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFF);
        ram[9]  = enc_r(5'd9, 5'd2, 5'd10, 6'h2A);
        ram[10] = enc_r(5'd2, 5'd3, 5'd11, 6'h3F);
        ram[11] = enc_i(6'h2B, 5'd0, 5'd4, 16'd61);
        ram[12] = enc_i(6'h2B, 5'd0, 5'd5, 16'd62);
        ram[13] = enc_i(6'h2B, 5'd0, 5'd6, 16'd63);
        ram[14] = enc_i(6'h2B, 5'd0, 5'd7, 16'd64);
        ram[15] = enc_i(6'h2B, 5'd0, 5'd8, 16'd65);
        ram[16] = enc_i(6'h2B, 5'd0, 5'd0, 16'd66);
        ram[17] = enc_i(6'h2B, 5'd0, 5'd10, 16'd67);
        ram[18] = enc_i(6'h2B, 5'd0, 5'd11, 16'd68);
        ram[19] = enc_j(26'd19);
        exp_q.push_back('{addr: 32'd61, data: 32'hFFFF_FFFE});
        exp_q.push_back('{addr: 32'd62, data: 32'd1});
        exp_q.push_back('{addr: 32'd63, data: 32'd1});
        exp_q.push_back('{addr: 32'd64, data: 32'd15});
        exp_q.push_back('{addr: 32'd65, data: 32'd16});
        exp_q.push_back('{addr: 32'd66, data: 32'd0});
        exp_q.push_back('{addr: 32'd67, data: 32'd1});
        exp_q.push_back('{addr: 32'd68, data: 32'd0});
        do_reset();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("q_empty_prog2", 32'(exp_q.size()), 32'd0);
        base = wr_count;
        repeat (20) @(negedge clk);
        chk("no_extra_writes", 32'(wr_count), 32'(base));

        // Conditional branches at PC=4
        clear_ram();
        ram[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        ram[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
        ram[2] = 32'd0;
        ram[3] = 32'd0;
        ram[4] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
        ram[5] = enc_j(26'd5);
        ram[6] = enc_j(26'd6);
        ram[7] = enc_i(6'h05, 5'd1, 5'd2, 16'd5);
        ram[8] = enc_j(26'd8);
        do_reset();
        wait_fetch_at(8'd4, "reach_beq");
        next_fetch("beq_done", ncyc);
`ifdef CPU_BRANCH_EN
        chk("beq_target", 32'(pc_debug), 32'd7);
        chk("beq_cycles", 32'(ncyc), 32'd3);
        next_fetch("bne_done", ncyc);
        chk("bne_not_taken", 32'(pc_debug), 32'd8);
        chk("bne_cycles", 32'(ncyc), 32'd3);
`else
        chk("beq_as_nop", 32'(pc_debug), 32'd5);
        chk("beq_nop_cycles", 32'(ncyc), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
